// File: rtl/mult_booth_if.sv
// Operand/result bundle between the control unit and the Booth multiplier.
// The control unit drives start/A/B and reads back hi/lo with busy/done status.
interface mult_booth_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;

  modport master (
    output start, A, B,
    input  hi, lo, busy, done
  );

  modport slave (
    input  start, A, B,
    output hi, lo, busy, done
  );
endinterface

// File: rtl/mult_booth.sv
// Sequential signed multiplier, radix-2 Booth recoding, one iteration per clock.
// Produces the exact 2*WIDTH-bit product split into hi/lo after WIDTH cycles.
module mult_booth #(
  parameter int WIDTH = 32
) (
  input  logic         clock,
  input  logic         reset,
  mult_booth_if.slave  bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q;
  logic [WIDTH:0]   m_q;
  logic [WIDTH:0]   acc_q;
  logic [WIDTH-1:0] q_q;
  logic             q1_q;
  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             busy_q;
  logic             done_q;

  logic [WIDTH:0]     acc_sum_d;
  logic [2*WIDTH+1:0] shift_d;
  logic [WIDTH:0]     acc_d;
  logic [WIDTH-1:0]   q_d;
  logic               q1_d;

  // One extra accumulator bit lets -M for M = -2^(WIDTH-1) be represented exactly.
  always_comb begin
    acc_sum_d = acc_q;
    case ({q_q[0], q1_q})
      2'b01:   acc_sum_d = acc_q + m_q;
      2'b10:   acc_sum_d = acc_q - m_q;
      default: acc_sum_d = acc_q;
    endcase
  end

  // Arithmetic right shift of {acc, q, q_1}; the old q_1 falls off the end.
  assign shift_d = {acc_sum_d[WIDTH], acc_sum_d, q_q};
  assign acc_d   = shift_d[2*WIDTH+1:WIDTH+1];
  assign q_d     = shift_d[WIDTH:1];
  assign q1_d    = shift_d[0];

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      m_q     <= '0;
      acc_q   <= '0;
      q_q     <= '0;
      q1_q    <= 1'b0;
      count_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            m_q     <= {bus.A[WIDTH-1], bus.A};
            acc_q   <= '0;
            q_q     <= bus.B;
            q1_q    <= 1'b0;
            count_q <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          acc_q   <= acc_d;
          q_q     <= q_d;
          q1_q    <= q1_d;
          count_q <= count_q + 1'b1;
          if (count_q == LAST_ITER) begin
            hi_q    <= acc_d[WIDTH-1:0];
            lo_q    <= q_d;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
endmodule

// File: doc/mult_booth.md
Name: mult_booth

Overview:
- Sequential signed multiplier for the CPU datapath; the arithmetic counterpart of the HI/LO divider.
- Takes two 32-bit two's-complement operands and produces the 64-bit product split into hi (upper 32 bits) and lo (lower 32 bits) for the MULT instruction.
- Uses radix-2 Booth recoding, one iteration per clock.
- The control unit starts it with a one-cycle pulse and waits for done before reading hi/lo.

Parameters:
WIDTH, 32, operand width; product is 2*WIDTH bits; latency scales with WIDTH.

Ports:
clock  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-low reset (0 at a rising edge clears the block)
start  input  1  request pulse; sampled only in IDLE
A  input  WIDTH  multiplicand, signed; sampled on accepted start
B  input  WIDTH  multiplier, signed; sampled on accepted start
hi  output  WIDTH  upper half of last completed product
lo  output  WIDTH  lower half of last completed product
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse when hi/lo are updated

Behaviour:
- Reset (reset==0 at a rising edge):
  - state=IDLE; hi=0, lo=0, busy=0, done=0; counter and internal registers cleared.
  - Overrides start and aborts any operation in progress; no done pulse and no hi/lo update for the aborted operation.
- States: IDLE, RUN.
- IDLE:
  - start==1 at edge k: latch M=A sign-extended to WIDTH+1 bits.
  - Load accumulator ACC (WIDTH+1 bits)=0, Q=B, q_1=0, count=0.
  - state->RUN, busy=1.
  - start==0: hold; outputs unchanged except done, which is forced to 0.
- RUN, each edge:
  - Examine {Q[0],q_1}: 01 -> ACC=ACC+M; 10 -> ACC=ACC-M; 00/11 -> no add.
  - Then arithmetic right shift of {ACC,Q,q_1} by 1, with ACC MSB replicated.
  - count=count+1.
- Completion: on the edge where the WIDTH-th iteration completes (edge k+WIDTH):
  - hi=ACC[WIDTH-1:0] and lo=Q, taken from the post-shift value.
  - done=1 for exactly one cycle; busy=0; state->IDLE.
- Latency: start accepted at edge k; done visible after edge k+WIDTH, i.e. 32 cycles for WIDTH=32.
- Accumulator must be WIDTH+1 bits so that M = -2^(WIDTH-1) subtracts without overflow; the result is exact for all operand pairs, including most-negative × most-negative.
- start while busy==1 is ignored (not queued).
- start in the cycle done==1 is accepted (state is already IDLE); back-to-back throughput is one product per WIDTH+1 cycles.
- A/B changes after the accepted start do not affect the result.
- hi/lo hold the last completed product until the next completion or reset; they never show intermediate values.
- No overflow or exception output: the 2*WIDTH result is always exact.
- busy and done are never high in the same cycle.

Test Plan:
- Reset released; start, A=3, B=5 -> done pulse exactly 32 cycles after start edge; hi=0x00000000, lo=0x0000000F; busy high for 32 cycles, low with done.
- A=-7 (0xFFFFFFF9), B=6 -> hi=0xFFFFFFFF, lo=0xFFFFFFD6.
- A=B=0x80000000 -> hi=0x40000000, lo=0x00000000. A=B=0x7FFFFFFF -> hi=0x3FFFFFFF, lo=0x00000001.
- start A=2,B=2; pulse start again with A=9,B=9 at cycle 10 while busy; change A/B mid-run -> single done, hi=0, lo=4; second start is ignored.
- Complete A=4,B=4 (lo=16); start A=5,B=5, drive reset=0 for one edge at cycle 12 -> busy=0, done never pulses, hi=lo=0. New start A=5,B=5 after release -> lo=25 after 32 cycles.
- Back-to-back: start held high through the done cycle with A=1,B=-1 -> first result hi=lo=0xFFFFFFFF; second operation accepted in the done cycle, next done exactly 33 cycles after the first.
